// File: rtl/adc_serdes_frame_aligner.sv
// Word-boundary aligner and sample rebuilder for a 2-lane-per-channel serial ADC link.
// It hunts the frame-clock word with bitslip, then interleaves the odd and even lane words into samples.
module adc_serdes_frame_aligner #(
  parameter logic [7:0] g_frame_pattern = 8'hF0,
  parameter int         g_slip_wait     = 3,
  parameter int         g_init_wait     = 16,
  parameter int         g_lock_count    = 4,
  parameter int         g_unlock_count  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        resync_i,
  input  logic [7:0]  serdes_fr_i,
  input  logic [63:0] serdes_data_i,
  output logic        bitslip_o,
  output logic        locked_o,
  output logic        sync_err_o,
  output logic [2:0]  slip_cnt_o,
  output logic [7:0]  unlock_cnt_o,
  output logic [63:0] sample_o,
  output logic        sample_valid_o,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_CHECK  = 3'd1,
    S_SLIP   = 3'd2,
    S_WAIT   = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  localparam logic [15:0] INIT_LAST   = 16'(g_init_wait - 1);
  localparam logic [15:0] WAIT_LAST   = 16'(g_slip_wait - 1);
  localparam logic [7:0]  LOCK_LAST   = 8'(g_lock_count - 1);
  localparam logic [7:0]  UNLOCK_LAST = 8'(g_unlock_count - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_match;
  logic [7:0]  r_mismatch;
  logic [2:0]  r_slip_cnt;
  logic [7:0]  r_unlock_cnt;
  logic        r_bitslip;
  logic        r_locked;
  logic        r_sync_err;
  logic [63:0] r_sample;
  logic        r_sample_valid;
  logic        w_fr_match;
  logic [63:0] w_sample;

  assign w_fr_match = (serdes_fr_i == g_frame_pattern);

  // Handshake-free datapath: bitslip_o is a bare one-clock strobe, sample_valid_o qualifies
  // sample_o on every clock it is high, and there is no backpressure anywhere.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_INIT;
      r_cnt        <= '0;
      r_match      <= '0;
      r_mismatch   <= '0;
      r_slip_cnt   <= '0;
      r_unlock_cnt <= '0;
      r_bitslip    <= 1'b0;
      r_locked     <= 1'b0;
      r_sync_err   <= 1'b0;
    end else if (resync_i) begin
      r_state    <= S_INIT;
      r_cnt      <= '0;
      r_match    <= '0;
      r_mismatch <= '0;
      r_slip_cnt <= '0;
      r_bitslip  <= 1'b0;
      r_locked   <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_bitslip <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (r_cnt == INIT_LAST) begin
            r_state <= S_CHECK;
            r_cnt   <= '0;
            r_match <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_CHECK: begin
          if (w_fr_match) begin
            if (r_match == LOCK_LAST) begin
              r_state    <= S_LOCKED;
              r_locked   <= 1'b1;
              r_match    <= '0;
              r_mismatch <= '0;
            end else begin
              r_match <= r_match + 8'd1;
            end
          end else begin
            r_state   <= S_SLIP;
            r_bitslip <= 1'b1;
          end
        end
        S_SLIP: begin
          // Wrapping back to zero means eight slips have gone by without finding the frame.
          r_slip_cnt <= r_slip_cnt + 3'd1;
          r_match    <= '0;
          r_cnt      <= '0;
          r_state    <= S_WAIT;
          if (r_slip_cnt == 3'd7) begin
            r_sync_err <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == WAIT_LAST) begin
            r_state <= S_CHECK;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_LOCKED: begin
          if (w_fr_match) begin
            r_mismatch <= '0;
          end else if (r_mismatch == UNLOCK_LAST) begin
            r_state    <= S_SLIP;
            r_bitslip  <= 1'b1;
            r_locked   <= 1'b0;
            r_mismatch <= '0;
            if (r_unlock_cnt != 8'hFF) begin
              r_unlock_cnt <= r_unlock_cnt + 8'd1;
            end
          end else begin
            r_mismatch <= r_mismatch + 8'd1;
          end
        end
        default: begin
          r_state  <= S_INIT;
          r_cnt    <= '0;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // Odd lane carries the odd sample bits, even lane the even ones, MSB pair first.
  always_comb begin
    w_sample = '0;
    for (int ch = 0; ch < 4; ch++) begin
      for (int k = 0; k < 8; k++) begin
        w_sample[16*ch + 2*k + 1] = serdes_data_i[16*ch + 8 + k];
        w_sample[16*ch + 2*k]     = serdes_data_i[16*ch + k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample       <= w_sample;
      r_sample_valid <= (r_state == S_LOCKED);
    end
  end

  assign bitslip_o      = r_bitslip;
  assign locked_o       = r_locked;
  assign sync_err_o     = r_sync_err;
  assign slip_cnt_o     = r_slip_cnt;
  assign unlock_cnt_o   = r_unlock_cnt;
  assign sample_o       = r_sample;
  assign sample_valid_o = r_sample_valid;
  assign dbg_state_o    = r_state;

endmodule
